// File: rtl/mac_sequencer.sv
// mac_sequencer: host-facing batch controller for a multiply/accumulate datapath.
// Loads operand pairs into two FIFOs, kicks the multiplier then the adder,
// reads the batch result from a register file and publishes it with a slot tag.
module mac_sequencer #(
  parameter int MAX_PAIRS = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_start,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        in_ready,
  output logic [31:0] fifo0_in,
  output logic [31:0] fifo1_in,
  output logic        fifo0_we,
  output logic        fifo1_we,
  output logic        op_clear,
  output logic        multi_op_start,
  output logic        adder_op_start,
  input  logic        multi_op_done,
  input  logic        adder_op_done,
  input  logic [3:0]  data_count0,
  input  logic [3:0]  data_count1,
  output logic [2:0]  rAddr,
  input  logic [31:0] rData,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [2:0]  res_slot,
  output logic        busy,
  output logic        err_timeout
);

  localparam logic [3:0] MaxPairs     = 4'(MAX_PAIRS);
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    LOAD,
    MUL_START,
    MUL_WAIT,
    ADD_START,
    ADD_WAIT,
    READ,
    CAPTURE
  } state_e;

  state_e      state_q;
  logic [3:0]  pair_cnt_q;
  logic [3:0]  pair_cnt_d;
  logic [7:0]  wait_cnt_q;
  logic [2:0]  res_slot_q;
  logic [2:0]  slot_out_q;
  logic [2:0]  raddr_q;
  logic [31:0] res_data_q;
  logic        res_valid_q;
  logic        busy_q;
  logic        err_q;
  logic        op_clear_q;
  logic        mul_start_q;
  logic        add_start_q;
  logic        accept;
  logic        wait_expired;

  // Operand handshake: pairs flow straight through to both FIFOs while loading.
  always_comb begin
    in_ready     = (state_q == LOAD) && (data_count0 < MaxPairs) &&
                   (data_count1 < MaxPairs) && (pair_cnt_q < MaxPairs);
    accept       = in_ready && in_valid;
    fifo0_we     = accept;
    fifo1_we     = accept;
    fifo0_in     = in_a;
    fifo1_in     = in_b;
    pair_cnt_d   = pair_cnt_q + 4'd1;
    wait_expired = (wait_cnt_q == TimeoutLimit);
  end

  // Registered outputs.
  always_comb begin
    op_clear       = op_clear_q;
    multi_op_start = mul_start_q;
    adder_op_start = add_start_q;
    rAddr          = raddr_q;
    res_valid      = res_valid_q;
    res_data       = res_data_q;
    res_slot       = slot_out_q;
    busy           = busy_q;
    err_timeout    = err_q;
  end

  // Batch FSM; one-cycle pulses are raised on the edge entering the state
  // that owns them so they are high exactly while that state is current.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pair_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      res_slot_q  <= '0;
      slot_out_q  <= '0;
      raddr_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      op_clear_q  <= 1'b0;
      mul_start_q <= 1'b0;
      add_start_q <= 1'b0;
    end else begin
      op_clear_q  <= 1'b0;
      mul_start_q <= 1'b0;
      add_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_start) begin
            state_q    <= CLEAR;
            op_clear_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        CLEAR: begin
          pair_cnt_q <= '0;
          err_q      <= 1'b0;
          state_q    <= LOAD;
        end
        LOAD: begin
          if (accept) begin
            pair_cnt_q <= pair_cnt_d;
            if (in_last || (pair_cnt_d == MaxPairs)) begin
              state_q     <= MUL_START;
              mul_start_q <= 1'b1;
            end
          end
        end
        MUL_START: begin
          wait_cnt_q <= '0;
          state_q    <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (multi_op_done) begin
            state_q     <= ADD_START;
            add_start_q <= 1'b1;
          end else if (wait_expired) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ADD_START: begin
          wait_cnt_q <= '0;
          state_q    <= ADD_WAIT;
        end
        ADD_WAIT: begin
          if (adder_op_done) begin
            raddr_q <= res_slot_q;
            state_q <= READ;
          end else if (wait_expired) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        READ: begin
          // rData is sampled at the end of READ so the result is already
          // valid during CAPTURE, the cycle that reports it.
          res_data_q  <= rData;
          slot_out_q  <= res_slot_q;
          res_valid_q <= 1'b1;
          state_q     <= CAPTURE;
        end
        CAPTURE: begin
          res_slot_q <= res_slot_q + 3'd1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a small datapath responder model.
module tb_mac_sequencer;

  logic        clk;
  logic        reset_n;
  logic        cmd_start;
  logic        in_valid;
  logic        in_last;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_ready;
  logic [31:0] fifo0_in;
  logic [31:0] fifo1_in;
  logic        fifo0_we;
  logic        fifo1_we;
  logic        op_clear;
  logic        multi_op_start;
  logic        adder_op_start;
  logic        multi_op_done;
  logic        adder_op_done;
  logic [3:0]  data_count0;
  logic [3:0]  data_count1;
  logic [2:0]  rAddr;
  logic [31:0] rData;
  logic        res_valid;
  logic [31:0] res_data;
  logic [2:0]  res_slot;
  logic        busy;
  logic        err_timeout;

  mac_sequencer #(.MAX_PAIRS(8), .TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start),
    .in_valid(in_valid), .in_last(in_last), .in_a(in_a), .in_b(in_b),
    .in_ready(in_ready), .fifo0_in(fifo0_in), .fifo1_in(fifo1_in),
    .fifo0_we(fifo0_we), .fifo1_we(fifo1_we), .op_clear(op_clear),
    .multi_op_start(multi_op_start), .adder_op_start(adder_op_start),
    .multi_op_done(multi_op_done), .adder_op_done(adder_op_done),
    .data_count0(data_count0), .data_count1(data_count1),
    .rAddr(rAddr), .rData(rData), .res_valid(res_valid), .res_data(res_data),
    .res_slot(res_slot), .busy(busy), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: each slot returns a distinct recognisable word.
  assign rData = 32'hCAFE_0000 + 32'(rAddr);

  // FIFO occupancy model.
  logic [3:0] dc0, dc1;
  assign data_count0 = dc0;
  assign data_count1 = dc1;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dc0 <= '0;
      dc1 <= '0;
    end else if (op_clear) begin
      dc0 <= '0;
      dc1 <= '0;
    end else begin
      if (fifo0_we && dc0 != 4'd15) dc0 <= dc0 + 4'd1;
      if (fifo1_we && dc1 != 4'd15) dc1 <= dc1 + 4'd1;
    end
  end

  // Datapath responder: done pulse N cycles after each start (0 = never).
  int   mul_delay = 4;
  int   add_delay = 4;
  int   mpend = 0;
  int   apend = 0;
  logic mul_resp = 1'b0;
  logic add_resp = 1'b0;
  logic add_inject = 1'b0;
  assign multi_op_done = mul_resp;
  assign adder_op_done = add_resp | add_inject;

  always @(posedge clk) begin
    #1;
    mul_resp = 1'b0;
    add_resp = 1'b0;
    if (!reset_n) begin
      mpend = 0;
      apend = 0;
    end else begin
      if (mpend > 0) begin
        mpend--;
        if (mpend == 0) mul_resp = 1'b1;
      end
      if (apend > 0) begin
        apend--;
        if (apend == 0) add_resp = 1'b1;
      end
      if (multi_op_start && mul_delay > 0) mpend = mul_delay;
      if (adder_op_start && add_delay > 0) apend = add_delay;
    end
  end

  // Activity monitor, sampled mid-cycle.
  int          cyc = 0;
  int          n_clr = 0, n_wr0 = 0, n_wr1 = 0, n_ms = 0, n_as = 0, n_res = 0;
  int          ms_cyc = 0, as_cyc = 0;
  logic [2:0]  last_slot = '0;
  logic [2:0]  last_raddr = '0;
  logic [31:0] last_data = '0;
  logic [31:0] f0_q[$];
  logic [31:0] f1_q[$];

  always @(negedge clk) begin
    cyc++;
    if (op_clear) n_clr++;
    if (fifo0_we) begin
      n_wr0++;
      f0_q.push_back(fifo0_in);
    end
    if (fifo1_we) begin
      n_wr1++;
      f1_q.push_back(fifo1_in);
    end
    if (multi_op_start) begin
      n_ms++;
      ms_cyc = cyc;
    end
    if (adder_op_start) begin
      n_as++;
      as_cyc = cyc;
    end
    if (res_valid) begin
      n_res++;
      last_slot  = res_slot;
      last_data  = res_data;
      last_raddr = rAddr;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tick();
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b,
                           input logic last, input int bound, output bit ok);
    in_a = a;
    in_b = b;
    in_last = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 700 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    check(tag, 32'(ok), 32'd1);
    tick();
  endtask

  task automatic run_batch(input string tag);
    bit ok;
    start_batch();
    send_pair(32'd1, 32'd1, 1'b1, 10, ok);
    check({tag, "_acc"}, 32'(ok), 32'd1);
    wait_idle({tag, "_idle"});
  endtask

  int  c_clr, c_wr, c_ms, c_as, c_res, base, acc, n;
  bit  ok;

  initial begin
    reset_n = 1'b0;
    cmd_start = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_a = '0;
    in_b = '0;

    // Reset state
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_data", res_data, 32'd0);
    check("rst_slot", 32'(res_slot), 32'd0);
    check("rst_raddr", 32'(rAddr), 32'd0);
    check("rst_pulses", 32'({op_clear, multi_op_start, adder_op_start, fifo0_we}), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Basic three-pair batch
    c_clr = n_clr; c_wr = n_wr0; c_ms = n_ms; c_as = n_as; c_res = n_res;
    base = f0_q.size();
    start_batch();
    check("b1_busy", 32'(busy), 32'd1);
    send_pair(32'd2, 32'd3, 1'b0, 10, ok);
    send_pair(32'd4, 32'd5, 1'b0, 10, ok);
    send_pair(32'd6, 32'd7, 1'b1, 10, ok);
    wait_idle("b1_idle");
    check("b1_clr", 32'(n_clr - c_clr), 32'd1);
    check("b1_wr0", 32'(n_wr0 - c_wr), 32'd3);
    check("b1_wr1", 32'(n_wr1 - c_wr), 32'd3);
    check("b1_f0_0", f0_q[base], 32'd2);
    check("b1_f1_0", f1_q[base], 32'd3);
    check("b1_f0_2", f0_q[base+2], 32'd6);
    check("b1_f1_2", f1_q[base+2], 32'd7);
    check("b1_ms", 32'(n_ms - c_ms), 32'd1);
    check("b1_as", 32'(n_as - c_as), 32'd1);
    check("b1_gap", 32'(as_cyc - ms_cyc), 32'd5);
    check("b1_res", 32'(n_res - c_res), 32'd1);
    check("b1_slot", 32'(last_slot), 32'd0);
    check("b1_raddr", 32'(last_raddr), 32'd0);
    check("b1_data", last_data, 32'hCAFE_0000);
    check("b1_hold", res_data, 32'hCAFE_0000);
    check("b1_err", 32'(err_timeout), 32'd0);

    // Batch limit: ten offers, no last
    c_wr = n_wr0; c_ms = n_ms; c_res = n_res;
    acc = 0;
    start_batch();
    for (int i = 0; i < 10; i++) begin
      send_pair(32'(100 + i), 32'(200 + i), 1'b0, 3, ok);
      if (ok) acc++;
    end
    check("lim_acc", 32'(acc), 32'd8);
    check("lim_ready", 32'(in_ready), 32'd0);
    check("lim_wr", 32'(n_wr0 - c_wr), 32'd8);
    check("lim_ms", 32'(n_ms - c_ms), 32'd1);
    wait_idle("lim_idle");
    check("lim_res", 32'(n_res - c_res), 32'd1);
    check("lim_slot", 32'(last_slot), 32'd1);

    // Multiplier never finishes: timeout
    mul_delay = 0;
    c_res = n_res;
    start_batch();
    send_pair(32'd1, 32'd1, 1'b1, 10, ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (multi_op_start) ok = 1'b1;
    end
    check("to_ms_seen", 32'(ok), 32'd1);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (err_timeout) ok = 1'b1;
    end
    check("to_seen", 32'(ok), 32'd1);
    check("to_cycles", 32'(n), 32'd257);
    check("to_busy", 32'(busy), 32'd0);
    tick();
    tick();
    check("to_sticky", 32'(err_timeout), 32'd1);
    check("to_nores", 32'(n_res - c_res), 32'd0);
    mul_delay = 4;
    start_batch();
    @(negedge clk);
    check("to_cleared", 32'(err_timeout), 32'd0);
    tick();
    send_pair(32'd1, 32'd1, 1'b1, 10, ok);
    wait_idle("to_next_idle");
    check("to_next_slot", 32'(last_slot), 32'd2);

    // cmd_start during LOAD and adder done during MUL_WAIT are ignored
    c_clr = n_clr; c_ms = n_ms; c_as = n_as; c_res = n_res;
    start_batch();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tick();
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_clr", 32'(n_clr - c_clr), 32'd1);
    send_pair(32'd9, 32'd9, 1'b1, 10, ok);
    tick();
    add_inject = 1'b1;
    tick();
    add_inject = 1'b0;
    wait_idle("ign_idle");
    check("ign_ms", 32'(n_ms - c_ms), 32'd1);
    check("ign_as", 32'(n_as - c_as), 32'd1);
    check("ign_gap", 32'(as_cyc - ms_cyc), 32'd5);
    check("ign_res", 32'(n_res - c_res), 32'd1);
    check("ign_slot", 32'(last_slot), 32'd3);

    // Reset during ADD_WAIT
    c_res = n_res;
    start_batch();
    send_pair(32'd5, 32'd5, 1'b1, 10, ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (adder_op_start) ok = 1'b1;
    end
    check("ar_as_seen", 32'(ok), 32'd1);
    tick();
    reset_n = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_slot", 32'(res_slot), 32'd0);
    check("ar_data", res_data, 32'd0);
    check("ar_raddr", 32'(rAddr), 32'd0);
    check("ar_misc", 32'({res_valid, err_timeout, in_ready, op_clear, adder_op_start}), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    check("ar_nores", 32'(n_res - c_res), 32'd0);

    // Nine back-to-back batches: slot wraps after 7
    for (int b = 0; b < 9; b++) begin
      c_clr = n_clr;
      run_batch($sformatf("wrap%0d", b));
      check($sformatf("wrap%0d_slot", b), 32'(last_slot), 32'(b % 8));
      check($sformatf("wrap%0d_data", b), last_data, 32'hCAFE_0000 + 32'(b % 8));
      check($sformatf("wrap%0d_clr", b), 32'(n_clr - c_clr), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
